output_reporter: RTL and testbench
==================================

OUTPUT_REPORTER -- requirements
Module: output_reporter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, i_clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; divider = CLK_HZ/BAUD, integer-truncated, SHALL be >= 2.
REQ-003 Parameter N_OUT, default 10, redstone output width; legal range 9..16.
REQ-004 i_clk  in  1  single system clock; all state SHALL be on its rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_outputs  in  N_OUT  redstone output vector, asynchronous to i_clk.
REQ-007 i_sample  in  1  one-cycle strobe: compare the current synchronized snapshot against the last reported value.
REQ-008 i_force  in  1  one-cycle strobe: report the snapshot unconditionally.
REQ-009 o_tx  out  1  UART line: 8N1, LSB first, idle high.
REQ-010 o_busy  out  1  high from the first start bit until the last stop bit of a frame completes.
REQ-011 o_overflow  out  1  sticky flag: a pending snapshot was overwritten before it was sent.

Function
REQ-012 i_outputs SHALL pass through a 2-flop synchronizer; "snapshot" means the synchronizer output.
REQ-013 Change condition: i_sample high and snapshot differs from the last_reported register.
REQ-014 On a change condition or i_force, the snapshot SHALL be latched into the pending register and pending_valid set.
REQ-015 Frame: 3 bytes; byte0 = 0xA5; byte1 = snapshot[7:0]; byte2 = snapshot[N_OUT-1:8], zero-extended to 8 bits.
REQ-016 Each byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly one divider period.
REQ-017 Bytes within a frame SHALL be back-to-back, with no idle gap after each stop bit.
REQ-018 FSM states: IDLE, START, DATA, STOP, plus a byte index 0..2.
REQ-019 IDLE->START when pending_valid: move pending to the frame register, copy it to last_reported, clear pending_valid.
REQ-020 START->DATA->STOP follow bit-period expiry; a DATA bit counter runs 0..7.
REQ-021 STOP exit: if index < 2, go to START with index+1; otherwise go to IDLE.
REQ-022 Latency: a trigger in cycle n from IDLE SHALL drive o_tx low in cycle n+2 (pending latch at n+1, START at n+2).
REQ-023 A trigger while busy updates pending. If pending_valid was already set and the value differs, o_overflow SHALL set; the newest value wins.
REQ-024 A pending snapshot left at frame end starts the next frame on the cycle after the final stop bit ends (STOP->IDLE->START).
REQ-025 i_sample and i_force in the same cycle count as a single trigger (force semantics).
REQ-026 i_sample with no change SHALL have no effect, including while busy.
REQ-027 The frame register is stable for the whole frame; mid-frame input changes never alter transmitted bits.

Reset
REQ-028 Asserting i_rst_n low SHALL immediately force o_tx=1, o_busy=0, o_overflow=0, FSM=IDLE, pending_valid=0, and all counters=0.
REQ-029 Reset SHALL clear last_reported and the synchronizer flops to 0, so the first nonzero sample reports.
REQ-030 Reset mid-frame aborts the frame at once with no trailing bits; the line returns high.
REQ-031 Reset release SHALL be synchronized internally (async assert, sync deassert).

Structure
REQ-032 Shared package output_reporter_pkg: header constant 0xA5, FSM state enum, frame byte count (3).
REQ-033 One sub-module, uart_tx_byte, SHALL hold the divider counter, bit counter and shift register, with a start/done handshake.
REQ-034 Estimated total size: 150-250 lines of RTL.

Verification (CLK_HZ=50e6, BAUD=115200, divider 434, N_OUT=10)
REQ-035 Reset, hold i_outputs=0, pulse i_sample -> no frame; o_tx stays 1 and o_busy stays 0.
REQ-036 i_outputs=10'h2C3, wait 3 cycles, pulse i_sample -> bytes A5, C3, 02 decoded; each bit 434 cycles; frame 13020 cycles.
REQ-037 During the frame, set i_outputs to 0x001 then 0x002 with a sample after each -> o_overflow=1; next frame carries 0x002 and starts right after the prior stop bit.
REQ-038 Same value, i_force pulse -> frame sent; i_sample afterwards -> no frame.
REQ-039 Assert i_rst_n low at bit 5 of byte1 -> o_tx=1 in the same cycle; no further edges.
REQ-040 i_sample and i_force in the same cycle with a changed value -> exactly one frame sent.

Source files
------------

// File: rtl/output_reporter_pkg.sv
// Shared constants and FSM encoding for the redstone output reporter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package output_reporter_pkg;

  // First byte of every frame, lets the receiver find frame alignment.
  localparam logic [7:0] HDR_BYTE    = 8'hA5;
  localparam int         FRAME_BYTES = 3;
  localparam logic [1:0] LAST_BYTE   = 2'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/output_reporter_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, DIV cycles each.
// Latency: tx goes low on the edge that samples start (from IDLE or at stop-bit end).
// Backpressure: start is only honoured in IDLE or on the done cycle; otherwise ignored.
module uart_tx_byte
  import output_reporter_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  logic [7:0] data,
  output logic      done,
  output logic      tx,
  output tx_state_t state
);

  localparam int            CW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          bit_end;

  assign bit_end = (div_cnt == DIV_LAST);
  // done is asserted in the final cycle of the stop bit so a follow-on byte
  // can be started on the same edge with no idle gap.
  assign done    = (state == ST_STOP) && bit_end;

  // Bit sequencer: divider, bit counter, shift register and registered line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      if (state != ST_IDLE) begin
        div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_START;
            shift_q <= data;
            div_cnt <= '0;
            tx      <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            tx      <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx      <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (start) begin
              state   <= ST_START;
              shift_q <= data;
              tx      <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/output_reporter.sv
// Reports changes of the redstone output vector as 3-byte UART frames (A5, lo, hi).
// Latency: trigger in cycle n -> pending at n+1 -> start bit on o_tx at n+2.
// Backpressure: none; triggers while busy overwrite the single pending slot (o_overflow).
module output_reporter
  import output_reporter_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int N_OUT  = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_OUT-1:0] i_outputs,
  input  logic             i_sample,
  input  logic             i_force,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_overflow
);

  localparam int DIV = CLK_HZ / BAUD;

  if (DIV < 2) begin : g_bad_div
    $error("output_reporter: CLK_HZ/BAUD must be at least 2");
  end
  if (N_OUT < 9 || N_OUT > 16) begin : g_bad_width
    $error("output_reporter: N_OUT must be in 9..16");
  end

  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [N_OUT-1:0] sync_q1;
  logic [N_OUT-1:0] snap;
  logic [N_OUT-1:0] last_reported;
  logic [N_OUT-1:0] pending_q;
  logic             pending_vld;
  logic [N_OUT-1:0] frame_q;
  logic [1:0]       byte_idx;
  logic             trigger;
  logic             frame_start;
  logic             tx_start;
  logic             tx_done;
  logic [7:0]       tx_data;
  logic [7:0]       hi_byte;
  tx_state_t        tx_state;

  // Reset bridge: assert immediately, release two edges later on i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Two-flop synchronizer for the asynchronous output vector.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      snap    <= '0;
    end else begin
      sync_q1 <= i_outputs;
      snap    <= sync_q1;
    end
  end

  // A force (alone or together with sample) always reports; a sample only on change.
  assign trigger     = i_force || (i_sample && (snap != last_reported));
  assign frame_start = (tx_state == ST_IDLE) && pending_vld;

  assign hi_byte  = 8'(frame_q[N_OUT-1:8]);
  assign tx_data  = frame_start ? HDR_BYTE : ((byte_idx == 2'd0) ? frame_q[7:0] : hi_byte);
  assign tx_start = frame_start || (tx_done && (byte_idx != LAST_BYTE));

  // Pending slot: newest trigger wins, overwriting an unsent different value is flagged.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      pending_vld <= 1'b0;
      o_overflow  <= 1'b0;
    end else if (trigger) begin
      pending_q   <= snap;
      pending_vld <= 1'b1;
      if (pending_vld && !frame_start && (snap != pending_q)) o_overflow <= 1'b1;
    end else if (frame_start) begin
      pending_vld <= 1'b0;
    end
  end

  // Frame register and byte index; the frame register only loads between frames.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q       <= '0;
      last_reported <= '0;
      byte_idx      <= '0;
    end else if (frame_start) begin
      frame_q       <= pending_q;
      last_reported <= pending_q;
      byte_idx      <= '0;
    end else if (tx_done && (byte_idx != LAST_BYTE)) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

  uart_tx_byte #(
    .DIV (DIV)
  ) u_tx (
    .clk   (i_clk),
    .rst_n (rst_n),
    .start (tx_start),
    .data  (tx_data),
    .done  (tx_done),
    .tx    (o_tx),
    .state (tx_state)
  );

  assign o_busy = (tx_state != ST_IDLE);

endmodule

// File: tb/tb_output_reporter.sv
// Directed bench for output_reporter at 50 MHz / 115200 baud (434 cycles per bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_output_reporter;

  localparam int N_OUT = 10;
  localparam int DIV   = 434;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [N_OUT-1:0] i_outputs = '0;
  logic             i_sample = 1'b0;
  logic             i_force = 1'b0;
  logic             o_tx;
  logic             o_busy;
  logic             o_overflow;

  int checks = 0;
  int errors = 0;

  output_reporter #(
    .CLK_HZ (50_000_000),
    .BAUD   (115200),
    .N_OUT  (N_OUT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_outputs  (i_outputs),
    .i_sample   (i_sample),
    .i_force    (i_force),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  always #10 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic f);
    i_sample = s;
    i_force  = f;
    tick(1);
    i_sample = 1'b0;
    i_force  = 1'b0;
  endtask

  task automatic set_out(input logic [N_OUT-1:0] v);
    i_outputs = v;
    tick(3);
  endtask

  // Trigger, then confirm line still high one cycle later and low the cycle after.
  task automatic trigger_and_check(input string tag, input logic s, input logic f);
    pulse(s, f);
    check_val({tag, "_lat1"}, o_tx, 1'b1);
    tick(1);
    check_val({tag, "_lat2"}, o_tx, 1'b0);
  endtask

  // Entered in cycle 0 of the first start bit; samples each bit at offsets 0, 217, 433.
  task automatic rx_frame(input string tag, input logic [7:0] b1, input logic [7:0] b2);
    logic [29:0] bits;
    logic        first;
    logic        busy_last;
    int          bad;
    bad       = 0;
    busy_last = 1'b0;
    bits      = '0;
    check_val({tag, "_busy_start"}, o_busy, 1'b1);
    for (int j = 0; j < 30; j++) begin
      first = o_tx;
      tick(DIV / 2);
      bits[j] = o_tx;
      tick(DIV - DIV / 2 - 1);
      if (o_tx !== first || o_tx !== bits[j]) bad++;
      if (j == 29) busy_last = o_busy;
      tick(1);
    end
    check_val({tag, "_bit_timing"}, bad, 0);
    check_val({tag, "_framing"}, {bits[29], bits[19], bits[9], bits[20], bits[10], bits[0]}, 6'b111000);
    check_val({tag, "_byte0"}, bits[8:1], 8'hA5);
    check_val({tag, "_byte1"}, bits[18:11], b1);
    check_val({tag, "_byte2"}, bits[28:21], b2);
    check_val({tag, "_busy_last"}, busy_last, 1'b1);
    check_val({tag, "_busy_end"}, o_busy, 1'b0);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int lows;
    int busys;
    lows  = 0;
    busys = 0;
    repeat (n) begin
      tick(1);
      if (o_tx !== 1'b1) lows++;
      if (o_busy !== 1'b0) busys++;
    end
    check_val({tag, "_tx_low_cycles"}, lows, 0);
    check_val({tag, "_busy_cycles"}, busys, 0);
  endtask

  initial begin
    // Reset state
    tick(2);
    check_val("rst_tx", o_tx, 1'b1);
    check_val("rst_busy", o_busy, 1'b0);
    check_val("rst_ovf", o_overflow, 1'b0);
    i_rst_n = 1'b1;
    tick(5);

    // Sampling an unchanged all-zero vector sends nothing
    pulse(1'b1, 1'b0);
    watch_quiet("no_change", 100);

    // First change; two more changes mid-frame overflow the pending slot
    set_out(10'h2C3);
    trigger_and_check("f1", 1'b1, 1'b0);
    fork
      rx_frame("f1", 8'hC3, 8'h02);
      begin
        tick(2000);
        set_out(10'h001);
        pulse(1'b1, 1'b0);
        check_val("ovf_first_pending", o_overflow, 1'b0);
        tick(10);
        set_out(10'h002);
        pulse(1'b1, 1'b0);
        check_val("ovf_overwrite", o_overflow, 1'b1);
      end
    join
    check_val("gap_idle_cycle", o_tx, 1'b1);
    tick(1);
    check_val("next_frame_start", o_tx, 1'b0);
    rx_frame("f2", 8'h02, 8'h00);
    check_val("ovf_sticky", o_overflow, 1'b1);

    // Force resends an unchanged value; a plain sample afterwards does not
    trigger_and_check("force", 1'b0, 1'b1);
    rx_frame("f3", 8'h02, 8'h00);
    pulse(1'b1, 1'b0);
    watch_quiet("resample", 200);

    // Sample and force together count once
    set_out(10'h3FF);
    trigger_and_check("both", 1'b1, 1'b1);
    rx_frame("f4", 8'hFF, 8'h03);
    watch_quiet("single_frame", 1000);

    // Reset in the middle of bit 5 of byte1 (0x55 -> that bit is 0)
    set_out(10'h155);
    trigger_and_check("rst_frame", 1'b1, 1'b0);
    tick(16 * DIV + DIV / 2);
    check_val("pre_rst_bit", o_tx, 1'b0);
    i_rst_n = 1'b0;
    #1;
    check_val("midrst_tx", o_tx, 1'b1);
    check_val("midrst_busy", o_busy, 1'b0);
    check_val("midrst_ovf", o_overflow, 1'b0);
    tick(3);
    i_rst_n = 1'b1;
    watch_quiet("post_rst", 2000);

    // last_reported was cleared, so the held nonzero vector reports again
    trigger_and_check("after_rst", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
